// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// Holds access-size codes, FSM states and the legality rule.
package dmem_pkg;

  localparam int ADDR_W_DEF = 14;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    DONE,
    WRITE
  } state_t;

  function automatic logic legal(
    input logic       rd,
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~off[0];
      F3_W:        ok = (off == 2'b00);
      default:     ok = 1'b0;
    endcase
    // stores have no unsigned forms
    if (wr && f3[2]) ok = 1'b0;
    if (rd && wr) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Core-side load/store bundle between the pipeline and dmem_ctrl.
// master is the core, slave is the controller.
interface dmem_if;

  logic [31:0] ALUResult;
  logic [31:0] ReadData2;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic        stall;
  logic [31:0] ReadData;
  logic        misalign;

  modport master (
    output ALUResult, ReadData2, MemRead, MemWrite, funct3,
    input  stall, ReadData, misalign
  );

  modport slave (
    input  ALUResult, ReadData2, MemRead, MemWrite, funct3,
    output stall, ReadData, misalign
  );

endinterface

// File: rtl/dmem_lane.sv
// Byte/half lane extraction with extension for loads, and
// read-modify-write lane merging for sub-word stores.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];

    load_val = '0;
    case (funct3)
      F3_B:    load_val = {{24{b[7]}}, b};
      F3_BU:   load_val = {24'h0, b};
      F3_H:    load_val = {{16{h[15]}}, h};
      F3_HU:   load_val = {16'h0, h};
      F3_W:    load_val = rdata;
      default: load_val = '0;
    endcase

    merged = wdata;
    case (funct3[1:0])
      2'b00: begin
        merged = rdata;
        merged[{off, 3'b000} +: 8] = wdata[7:0];
      end
      2'b01: begin
        merged = rdata;
        merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: single-cycle SW, three-cycle loads and
// read-modify-write SB/SH against a single-port synchronous RAM.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_if.slave             bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic [31:0]       wd_q;
  logic [2:0]        f3_q;
  logic              st_q;
  logic [31:0]       res_q;

  logic              take;
  logic              req;
  logic              ok;
  logic              stall;
  logic              mis;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rd_out;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  logic unused_hi;
  assign unused_hi = ^bus.ALUResult[31:ADDR_W+2];

  assign req = bus.MemRead | bus.MemWrite;
  assign ok  = legal(bus.MemRead, bus.MemWrite,
                     bus.funct3, bus.ALUResult[1:0]);

  dmem_lane u_lane (
    .rdata    (ram_rdata),
    .wdata    (wd_q),
    .funct3   (f3_q),
    .off      (off_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    stall   = 1'b0;
    mis     = 1'b0;
    we      = 1'b0;
    addr    = bus.ALUResult[ADDR_W+1:2];
    wdata   = '0;
    rd_out  = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (!ok) begin
            mis = 1'b1;
          end else if (bus.MemWrite && bus.funct3 == F3_W) begin
            we    = 1'b1;
            wdata = bus.ReadData2;
          end else begin
            stall   = 1'b1;
            take    = 1'b1;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        stall   = 1'b1;
        addr    = addr_q;
        state_d = st_q ? WRITE : DONE;
      end
      DONE: begin
        addr    = addr_q;
        rd_out  = res_q;
        state_d = IDLE;
      end
      WRITE: begin
        addr    = addr_q;
        we      = 1'b1;
        wdata   = res_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // reset forces every output quiet regardless of the request
  assign bus.stall    = rst_n & stall;
  assign bus.misalign = rst_n & mis;
  assign bus.ReadData = rst_n ? rd_out : '0;
  assign ram_we       = rst_n & we;
  assign ram_addr     = rst_n ? addr : '0;
  assign ram_wdata    = rst_n ? wdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      wd_q    <= '0;
      f3_q    <= '0;
      st_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        addr_q <= bus.ALUResult[ADDR_W+1:2];
        off_q  <= bus.ALUResult[1:0];
        wd_q   <= bus.ReadData2;
        f3_q   <= bus.funct3;
        st_q   <= bus.MemWrite;
      end
      if (state_q == RD_WAIT)
        res_q <= st_q ? merged : load_val;
    end
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 14, RAM word-address width (64 KiB data RAM).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ALUResult  input  32  byte address from ALU; bits [ADDR_W+1:2] select the word, upper bits ignored.
REQ-005 ReadData2  input  32  store data from register file.
REQ-006 MemRead  input  1  load request; held stable by the core while stall=1.
REQ-007 MemWrite  input  1  store request; held stable by the core while stall=1.
REQ-008 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 stall  output  1  core must hold PC and the request while 1.
REQ-010 ReadData  output  32  aligned and extended load result.
REQ-011 misalign  output  1  one-cycle error pulse on an illegal access.
REQ-012 ram_addr  output  ADDR_W  word address to single-port RAM.
REQ-013 ram_we  output  1  RAM write enable.
REQ-014 ram_wdata  output  32  RAM write word.
REQ-015 ram_rdata  input  32  RAM read word, valid one cycle after ram_addr is presented with ram_we=0.

Function
REQ-016 The FSM SHALL have states IDLE, RD_WAIT, DONE and WRITE.
REQ-017 In IDLE, an aligned SW SHALL drive ram_we=1, ram_addr=ALUResult[ADDR_W+1:2] and ram_wdata=ReadData2 in the same cycle with stall=0, and the FSM SHALL remain in IDLE.
REQ-018 In IDLE, a legal load or SB/SH SHALL drive ram_addr with ram_we=0 and stall=1, latch address, ReadData2, funct3 and the access type, and move to RD_WAIT.
REQ-019 In RD_WAIT, stall=1; a load SHALL register the extended lane of ram_rdata and go to DONE; SB/SH SHALL register ram_rdata with the selected lane(s) replaced by ReadData2[7:0] or [15:0] and go to WRITE.
REQ-020 In DONE, stall=0 and ReadData SHALL equal the registered result; the FSM SHALL go to IDLE unconditionally.
REQ-021 In WRITE, stall=0 and ram_we=1 SHALL be driven with the latched address and merged word; the FSM SHALL go to IDLE unconditionally.
REQ-022 Latency: SW takes 1 cycle; loads, SB and SH take 3 cycles with stall=1 for exactly 2 of them.
REQ-023 Byte lanes SHALL be little-endian: byte lane = addr[1:0], half lane = addr[1].
REQ-024 LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend to 32 bits.
REQ-025 H/HU with addr[0]=1, W with addr[1:0]!=0, illegal funct3 (loads 011/110/111, stores >010), or MemRead&MemWrite=1 SHALL cause no RAM access, misalign=1 for one cycle, stall=0 and ReadData=0; the FSM SHALL stay in IDLE.
REQ-026 Outside DONE, ReadData SHALL be 0.
REQ-027 With no request in IDLE, ram_we=0, stall=0 and misalign=0.
REQ-028 Requests arriving in RD_WAIT, DONE or WRITE SHALL be ignored; only IDLE samples the inputs.

Reset
REQ-029 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE and every latched register SHALL clear to 0.
REQ-030 While rst_n=0, outputs SHALL be stall=0, ReadData=0, misalign=0, ram_we=0, ram_addr=0 and ram_wdata=0.
REQ-031 Reset during RD_WAIT SHALL abort the access with no RAM write issued.

Structure
REQ-032 Package dmem_pkg SHALL hold the funct3 size constants, the FSM state enum and the ADDR_W default.
REQ-033 A combinational sub-module dmem_lane SHALL implement load extraction/extension and store-lane merging; dmem_ctrl SHALL instantiate it once.

Verification
REQ-034 Scenario: RAM word 0x0 = 0x8899AABB, LB addr 0x3 -> stall high 2 cycles, then ReadData=0xFFFFFF88 for 1 cycle.
REQ-035 Scenario: same word, LHU addr 0x2 -> ReadData=0x00008899; LH addr 0x0 -> ReadData=0xFFFFAABB.
REQ-036 Scenario: SB addr 0x1 with ReadData2=0x000000CC over 0x8899AABB -> ram_we in the 3rd cycle with ram_wdata=0x8899CCBB.
REQ-037 Scenario: SW addr 0x10 with data 0x12345678 -> same-cycle ram_we=1, ram_addr=4, stall=0.
REQ-038 Scenario: LW addr 0x6, then SH addr 0x3 -> misalign pulse each, ram_we=0, stall=0, ReadData=0.
REQ-039 Scenario: rst_n=0 in RD_WAIT of an SH -> IDLE next cycle, no ram_we ever asserted, RAM word unchanged.
